branch_predictor: RTL and testbench

- Produces the `pred_take` consumed by the ID-stage branch resolution logic.
- Receives that logic's resolved outcome (`branch_take`, `pred_fail`) back as training.
- Gshare direction predictor: PC bits XOR a speculative global history register (GHR) index a pattern history table (PHT) of 2-bit saturating counters.
- Sits alongside decode; the lookup index and GHR snapshot travel down the pipe with the branch.

---
 rtl/branch_predictor_pkg.sv | 32 +++
 rtl/branch_predictor_pht_ram.sv | 28 ++
 rtl/branch_predictor.sv | 108 ++++++++++
 tb/tb_branch_predictor.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the gshare branch predictor: 2-bit counter
// encoding, saturating update and default geometry.
package branch_predictor_pkg;

  localparam int PHT_IDX_W_DEF = 10;
  localparam int GHR_W_DEF     = 8;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bp_state_e;

  // Move one step toward the resolved direction, saturating at SNT/ST.
  function automatic ctr_t ctr_update(input ctr_t ctr, input logic taken);
    ctr_t nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor_pht_ram.sv
// Pattern history table: one async read port, one sync read-modify-write port.
// The write port either forces WNT (initialisation) or trains the addressed counter.
module pht_ram
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W = PHT_IDX_W_DEF
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] raddr,
  output ctr_t             rdata,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic             w_init,
  input  logic             w_taken
);

  ctr_t mem_q [2**IDX_W];

  // Storage is deliberately unreset; the owner sweeps every entry after reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= w_init ? WNT : ctr_update(mem_q[waddr], w_taken);
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/branch_predictor.sv
// Gshare direction predictor: PC xor speculative global history indexes a PHT
// of 2-bit counters; resolution trains the PHT and repairs the history.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int PHT_IDX_W = PHT_IDX_W_DEF,
  parameter int GHR_W     = GHR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 ready,
  input  logic                 q_valid,
  input  logic [31:0]          q_pc,
  output logic                 pred_take,
  output logic [PHT_IDX_W-1:0] pred_idx,
  output logic [GHR_W-1:0]     pred_ghr,
  input  logic                 u_valid,
  input  logic [PHT_IDX_W-1:0] u_idx,
  input  logic [GHR_W-1:0]     u_ghr,
  input  logic                 u_taken,
  input  logic                 u_pred_fail
);

  // Handshake: q_valid/u_valid are single-cycle qualifiers with no backpressure;
  // both are ignored while ready is low, and each is consumed on the clock edge it is high.

  bp_state_e            state_q, state_d;
  logic [PHT_IDX_W-1:0] init_cnt_q, init_cnt_d;
  logic [GHR_W-1:0]     ghr_q, ghr_d;
  logic                 ready_q, ready_d;

  logic [PHT_IDX_W-1:0] lookup_idx;
  ctr_t                 rd_ctr;
  logic                 ram_we;
  logic [PHT_IDX_W-1:0] ram_waddr;
  logic                 ram_init;
  logic                 unused_pc_bits;

  assign lookup_idx     = q_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr_q);
  assign unused_pc_bits = ^{q_pc[31:PHT_IDX_W+2], q_pc[1:0]};

  pht_ram #(
    .IDX_W (PHT_IDX_W)
  ) u_pht_ram (
    .clk     (clk),
    .raddr   (lookup_idx),
    .rdata   (rd_ctr),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .w_init  (ram_init),
    .w_taken (u_taken)
  );

  // Prediction reads the pre-write counter even when an update targets the same entry.
  assign ready     = ready_q;
  assign pred_take = ready_q & rd_ctr[1];
  assign pred_idx  = ready_q ? lookup_idx : '0;
  assign pred_ghr  = ready_q ? ghr_q : '0;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ghr_d      = ghr_q;
    ready_d    = ready_q;
    ram_we     = 1'b0;
    ram_waddr  = u_idx;
    ram_init   = 1'b0;
    case (state_q)
      ST_INIT: begin
        ram_we     = 1'b1;
        ram_waddr  = init_cnt_q;
        ram_init   = 1'b1;
        init_cnt_d = init_cnt_q + 1'b1;
        if (&init_cnt_q) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        ram_we = u_valid;
        // A repair wins over speculation: the same-cycle younger branch is flushed.
        if (u_valid && u_pred_fail) begin
          ghr_d = GHR_W'({u_ghr, u_taken});
        end else if (q_valid) begin
          ghr_d = GHR_W'({ghr_q, pred_take});
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      ghr_q      <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ghr_q      <= ghr_d;
      ready_q    <= ready_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized
// traffic compared against an array-based gshare reference.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic        ready;
  logic        q_valid;
  logic [31:0] q_pc;
  logic        pred_take;
  logic [9:0]  pred_idx;
  logic [7:0]  pred_ghr;
  logic        u_valid;
  logic [9:0]  u_idx;
  logic [7:0]  u_ghr;
  logic        u_taken;
  logic        u_pred_fail;

  int checks;
  int failures;

  // Reference state: plain integer counters 0..3 and an integer history.
  int pht_m [1024];
  int ghr_m;

  logic       obs_take;
  logic [9:0] obs_idx;
  logic [7:0] obs_ghr;

  // In-flight predictions awaiting resolution in the random phase.
  int fl_idx_q [$];
  int fl_ghr_q [$];
  int fl_pred_q[$];

  branch_predictor dut (
    .clk         (clk),
    .rst         (rst),
    .ready       (ready),
    .q_valid     (q_valid),
    .q_pc        (q_pc),
    .pred_take   (pred_take),
    .pred_idx    (pred_idx),
    .pred_ghr    (pred_ghr),
    .u_valid     (u_valid),
    .u_idx       (u_idx),
    .u_ghr       (u_ghr),
    .u_taken     (u_taken),
    .u_pred_fail (u_pred_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) pht_m[i] = 1;
    ghr_m = 0;
  endtask

  task automatic drive(input logic qv, input logic [31:0] pc, input logic uv,
                       input logic [9:0] ui, input logic [7:0] ug,
                       input logic ut, input logic upf);
    q_valid     = qv;
    q_pc        = pc;
    u_valid     = uv;
    u_idx       = ui;
    u_ghr       = ug;
    u_taken     = ut;
    u_pred_fail = upf;
  endtask

  // One RUN cycle: drive, compare lookups against the model, clock, advance the model.
  task automatic step(input logic qv, input logic [31:0] pc, input logic uv,
                      input logic [9:0] ui, input logic [7:0] ug,
                      input logic ut, input logic upf);
    int idx_m;
    int pred_m;
    @(negedge clk);
    drive(qv, pc, uv, ui, ug, ut, upf);
    #1;
    idx_m  = ((pc >> 2) % 1024) ^ ghr_m;
    pred_m = (pht_m[idx_m] >= 2) ? 1 : 0;
    obs_take = pred_take;
    obs_idx  = pred_idx;
    obs_ghr  = pred_ghr;
    check_eq("ready", 32'(ready), 32'd1);
    check_eq("pred_take", 32'(pred_take), 32'(pred_m));
    check_eq("pred_idx", 32'(pred_idx), 32'(idx_m));
    check_eq("pred_ghr", 32'(pred_ghr), 32'(ghr_m));
    @(posedge clk);
    if (uv) begin
      if (ut) pht_m[ui] = (pht_m[ui] == 3) ? 3 : pht_m[ui] + 1;
      else    pht_m[ui] = (pht_m[ui] == 0) ? 0 : pht_m[ui] - 1;
    end
    if (uv && upf)   ghr_m = ((int'(ug) * 2) + int'(ut)) % 256;
    else if (qv)     ghr_m = ((ghr_m * 2) + pred_m) % 256;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Counts clock edges until ready rises, with a bounded wait; junk inputs optional.
  task automatic wait_ready(input string tag, input bit junk, input int limit, output int n);
    n = 0;
    check_eq({tag, "_ready_low"}, 32'(ready), 32'd0);
    while (!ready && n < 3000) begin
      if (junk) drive(1'b1, $urandom, 1'b1, 10'h010, 8'hFF, 1'b1, 1'b1);
      @(posedge clk);
      n++;
      #1;
      if (n == limit) break;
    end
  endtask

  logic [31:0] pc_r;
  int n_cyc;
  int idx_r, pred_r, taken_r;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 10'h0, 8'h0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);

    // Reset sweep: ready rises exactly 1024 edges after the reset edge.
    pulse_reset();
    wait_ready("sweep", 1'b0, 0, n_cyc);
    check_eq("sweep_len", 32'(n_cyc), 32'd1024);
    step(1'b0, 32'h0000_0AB4, 1'b0, 10'h0, 8'h0, 1'b0, 1'b0);
    check_eq("sweep_wnt", 32'(obs_take), 32'd0);

    // Reset mid-INIT with junk traffic that must be ignored.
    pulse_reset();
    wait_ready("mid_a", 1'b1, 500, n_cyc);
    check_eq("mid_a_not_ready", 32'(ready), 32'd0);
    pulse_reset();
    wait_ready("mid_b", 1'b1, 0, n_cyc);
    check_eq("mid_len", 32'(n_cyc), 32'd1024);
    step(1'b0, 32'h0000_0040, 1'b0, 10'h0, 8'h0, 1'b0, 1'b0);
    check_eq("mid_ghr_clean", 32'(obs_ghr), 32'h0);
    check_eq("mid_pht_clean", 32'(obs_take), 32'd0);

    // Training at idx 0x010 with GHR 0: saturate up, then down.
    step(1'b0, 32'h40, 1'b1, 10'h010, 8'h0, 1'b1, 1'b0);
    check_eq("train_01", 32'(obs_take), 32'd0);
    step(1'b0, 32'h40, 1'b1, 10'h010, 8'h0, 1'b1, 1'b0);
    check_eq("train_10", 32'(obs_take), 32'd1);
    step(1'b0, 32'h40, 1'b1, 10'h010, 8'h0, 1'b1, 1'b0);
    check_eq("train_11", 32'(obs_take), 32'd1);
    step(1'b0, 32'h40, 1'b1, 10'h010, 8'h0, 1'b0, 1'b0);
    check_eq("train_sat11", 32'(obs_take), 32'd1);
    step(1'b0, 32'h40, 1'b1, 10'h010, 8'h0, 1'b0, 1'b0);
    check_eq("train_dn10", 32'(obs_take), 32'd1);
    step(1'b0, 32'h40, 1'b1, 10'h010, 8'h0, 1'b0, 1'b0);
    check_eq("train_dn01", 32'(obs_take), 32'd0);
    step(1'b0, 32'h40, 1'b1, 10'h010, 8'h0, 1'b0, 1'b0);
    check_eq("train_dn00", 32'(obs_take), 32'd0);
    step(1'b0, 32'h40, 1'b1, 10'h010, 8'h0, 1'b1, 1'b0);
    check_eq("train_sat00", 32'(obs_take), 32'd0);
    step(1'b0, 32'h40, 1'b0, 10'h0, 8'h0, 1'b0, 1'b0);
    check_eq("train_up01", 32'(obs_take), 32'd0);

    // Speculation: prime entries 0x040 (taken), 0x080 (not), 0x0C0 (taken).
    for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 1'b1, 10'h040, 8'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 10'h080, 8'h0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 1'b1, 10'h0C0, 8'h0, 1'b1, 1'b0);
    step(1'b1, 32'h100, 1'b0, 10'h0, 8'h0, 1'b0, 1'b0);
    check_eq("spec1_take", 32'(obs_take), 32'd1);
    check_eq("spec1_ghr", 32'(obs_ghr), 32'h00);
    step(1'b1, 32'h204, 1'b0, 10'h0, 8'h0, 1'b0, 1'b0);
    check_eq("spec2_take", 32'(obs_take), 32'd0);
    check_eq("spec2_ghr", 32'(obs_ghr), 32'h01);
    step(1'b1, 32'h308, 1'b0, 10'h0, 8'h0, 1'b0, 1'b0);
    check_eq("spec3_take", 32'(obs_take), 32'd1);
    check_eq("spec3_ghr", 32'(obs_ghr), 32'h02);
    step(1'b0, 32'h0, 1'b1, 10'h155, 8'hAA, 1'b1, 1'b0);
    check_eq("spec_final_ghr", 32'(obs_ghr), 32'h05);

    // Repair beats a same-cycle speculative shift.
    step(1'b1, 32'h100, 1'b1, 10'h3FF, 8'h3C, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 10'h0, 8'h0, 1'b0, 1'b0);
    check_eq("repair_ghr", 32'(obs_ghr), 32'h78);

    // Same-index collision: prediction sees the pre-write counter.
    step(1'b1, 32'h9E0, 1'b1, 10'h200, 8'h0, 1'b1, 1'b0);
    check_eq("collide_idx", 32'(obs_idx), 32'h200);
    check_eq("collide_old", 32'(obs_take), 32'd0);
    step(1'b0, 32'hBC0, 1'b0, 10'h0, 8'h0, 1'b0, 1'b0);
    check_eq("collide_new_idx", 32'(obs_idx), 32'h200);
    check_eq("collide_new", 32'(obs_take), 32'd1);

    // Random traffic: lookups are queued and resolved a few cycles later.
    for (int c = 0; c < 600; c++) begin
      logic qv, uv;
      logic [9:0] ui;
      logic [7:0] ug;
      logic ut, upf;
      qv = ($urandom_range(0, 99) < 60);
      pc_r = $urandom_range(0, 255) << 2;
      uv = 1'b0; ui = '0; ug = '0; ut = 1'b0; upf = 1'b0;
      if (fl_idx_q.size() > 0 && $urandom_range(0, 99) < 55) begin
        idx_r   = fl_idx_q.pop_front();
        ug      = 8'(fl_ghr_q.pop_front());
        pred_r  = fl_pred_q.pop_front();
        taken_r = ($urandom_range(0, 99) < 65) ? 1 : 0;
        uv  = 1'b1;
        ui  = 10'(idx_r);
        ut  = taken_r[0];
        upf = ut ^ pred_r[0];
        if (upf) begin
          fl_idx_q.delete();
          fl_ghr_q.delete();
          fl_pred_q.delete();
        end
      end else if ($urandom_range(0, 99) < 10) begin
        uv = 1'b1; ui = 10'($urandom); ug = 8'($urandom);
        ut = 1'($urandom); upf = 1'($urandom);
      end
      step(qv, pc_r, uv, ui, ug, ut, upf);
      if (qv && !(uv && upf)) begin
        fl_idx_q.push_back(int'(obs_idx));
        fl_ghr_q.push_back(int'(obs_ghr));
        fl_pred_q.push_back(int'(obs_take));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got 0x0 expected 0x1");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
